ntt_cmd_scheduler: RTL and testbench

Command sequencer in front of ntt_processer. It buffers polynomial-operation commands (NTT, INVNTT, MULT, ADDSUB) from the Kyber top-level control in a small FIFO and issues them one at a time with a one-cycle start pulse and stable operand fields. It waits for NTT_finish, then pulses a local soft reset to return the engine from its terminal LAST_CYCLE state, and reports per-command completion with a tag. A watchdog aborts hung operations.

---
 rtl/ntt_cmd_scheduler_if.sv | 37 +++
 rtl/ntt_cmd_scheduler.sv | 153 +++++++++++++++
 tb/tb_ntt_cmd_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_cmd_scheduler_if.sv
// Command channel into the NTT command scheduler.
// The producer drives valid and the fields; the scheduler returns ready.
`timescale 1ns/1ps
interface ntt_cmd_scheduler_if #(
  parameter int TAG_W = 2
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_is_add_or_sub;
  logic [9:0]       cmd_offset_A;
  logic [9:0]       cmd_offset_B;
  logic [9:0]       cmd_offset_W;
  logic [TAG_W-1:0] cmd_tag;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_is_add_or_sub,
    output cmd_offset_A,
    output cmd_offset_B,
    output cmd_offset_W,
    output cmd_tag,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_is_add_or_sub,
    input  cmd_offset_A,
    input  cmd_offset_B,
    input  cmd_offset_W,
    input  cmd_tag,
    output cmd_ready
  );
endinterface

// File: rtl/ntt_cmd_scheduler.sv
// Buffers polynomial commands and issues them one at a time to the NTT
// engine, soft-resetting it after each finish and aborting hung runs.
`timescale 1ns/1ps
module ntt_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  ntt_cmd_scheduler_if.slave       cmd,
  output logic                     start,
  output logic [1:0]               mode,
  output logic                     is_add_or_sub,
  output logic [9:0]               ram_r_start_offset_A,
  output logic [9:0]               ram_r_start_offset_B,
  output logic [9:0]               ram_w_start_offset,
  output logic                     ntt_rst,
  input  logic                     NTT_finish,
  output logic                     busy,
  output logic                     done,
  output logic [TAG_W-1:0]         done_tag,
  output logic                     done_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [1:0]       mode;
    logic             sub;
    logic [9:0]       a;
    logic [9:0]       b;
    logic [9:0]       w;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RECOVER
  } state_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          in_c;
  cmd_t          cur_q;
  state_t        state_q;
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic [CW-1:0] wd_q;
  logic          start_q;
  logic          ntt_rst_q;
  logic          done_q;
  logic          err_q;
  logic          push;
  logic          pop;

  always_comb begin
    in_c      = '0;
    in_c.mode = cmd.cmd_mode;
    in_c.sub  = cmd.cmd_is_add_or_sub;
    in_c.a    = cmd.cmd_offset_A;
    in_c.b    = cmd.cmd_offset_B;
    in_c.w    = cmd.cmd_offset_W;
    in_c.tag  = cmd.cmd_tag;
  end

  assign cmd.cmd_ready = (cnt_q != FULL);
  assign push = cmd.cmd_valid & cmd.cmd_ready;
  assign pop  = (state_q == IDLE) && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Pulse outputs default low and are raised only on the entering edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      wd_q      <= '0;
      start_q   <= 1'b0;
      ntt_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      ntt_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            cur_q   <= mem_q[rp_q];
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          wd_q <= wd_q + 1'b1;
          if (NTT_finish || wd_q == WD_LAST) begin
            err_q     <= ~NTT_finish;
            ntt_rst_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= RECOVER;
          end
        end
        RECOVER: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start                = start_q;
  assign mode                 = cur_q.mode;
  assign is_add_or_sub        = cur_q.sub;
  assign ram_r_start_offset_A = cur_q.a;
  assign ram_r_start_offset_B = cur_q.b;
  assign ram_w_start_offset   = cur_q.w;
  assign ntt_rst              = ntt_rst_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = done_q;
  assign done_tag             = cur_q.tag;
  assign done_err             = err_q;
  assign fifo_level           = cnt_q;

endmodule

// File: tb/tb_ntt_cmd_scheduler.sv
// Directed bench for ntt_cmd_scheduler with a simple engine model
// that raises finish a programmable number of cycles after start.
`timescale 1ns/1ps
module tb_ntt_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       is_add_or_sub;
  logic [9:0] offA;
  logic [9:0] offB;
  logic [9:0] offW;
  logic       ntt_rst;
  logic       NTT_finish;
  logic       busy;
  logic       done;
  logic [1:0] done_tag;
  logic       done_err;
  logic [2:0] fifo_level;

  ntt_cmd_scheduler_if #(.TAG_W(2)) cif ();

  ntt_cmd_scheduler #(
    .DEPTH(4),
    .TAG_W(2),
    .TIMEOUT(300)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd                  (cif),
    .start                (start),
    .mode                 (mode),
    .is_add_or_sub        (is_add_or_sub),
    .ram_r_start_offset_A (offA),
    .ram_r_start_offset_B (offB),
    .ram_w_start_offset   (offW),
    .ntt_rst              (ntt_rst),
    .NTT_finish           (NTT_finish),
    .busy                 (busy),
    .done                 (done),
    .done_tag             (done_tag),
    .done_err             (done_err),
    .fifo_level           (fifo_level)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int fin_delay = 0;
  int ecnt = 0;
  int peak = 0;
  logic run = 1'b0;
  logic [1:0] dq_tag [$];
  logic       dq_err [$];
  int         sq [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: finish holds from fin_delay cycles after start until ntt_rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      ecnt <= 0;
    end else if (ntt_rst) begin
      run <= 1'b0;
    end else if (start) begin
      run  <= 1'b1;
      ecnt <= 1;
    end else if (run && ecnt < fin_delay) begin
      ecnt <= ecnt + 1;
    end
  end

  assign NTT_finish = run && (fin_delay != 0) && (ecnt == fin_delay);

  always @(negedge clk) begin
    if (done) begin
      dq_tag.push_back(done_tag);
      dq_err.push_back(done_err);
    end
    if (start) sq.push_back(cyc);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [1:0] m, input logic s,
                      input logic [9:0] a, input logic [9:0] b,
                      input logic [9:0] w, input logic [1:0] t,
                      output int stall);
    cif.cmd_mode          = m;
    cif.cmd_is_add_or_sub = s;
    cif.cmd_offset_A      = a;
    cif.cmd_offset_B      = b;
    cif.cmd_offset_W      = w;
    cif.cmd_tag           = t;
    cif.cmd_valid         = 1'b1;
    stall = 0;
    while (!cif.cmd_ready && stall < 1000) begin
      @(negedge clk);
      stall++;
    end
    chk("push_ready", cif.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!start && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", start, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int st;
    int k;
    logic [1:0] tg [6];
    tg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    cif.cmd_valid = 1'b0;
    cif.cmd_mode = '0;
    cif.cmd_is_add_or_sub = 1'b0;
    cif.cmd_offset_A = '0;
    cif.cmd_offset_B = '0;
    cif.cmd_offset_W = '0;
    cif.cmd_tag = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", cif.cmd_ready, 1);
    chk("rst_pulses", {start, done, done_err, ntt_rst, busy}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_offs", {offA, offB, offW}, 0);
    chk("rst_misc", {mode, is_add_or_sub, done_tag}, 0);
    rst = 1'b0;
    @(negedge clk);

    // single NTT, finish 229 cycles after start
    fin_delay = 229;
    push(2'd0, 1'b0, 10'h000, 10'h000, 10'h040, 2'd1, st);
    chk("t1_pre_start", start, 0);
    chk("t1_level", fifo_level, 1);
    @(negedge clk);
    chk("t1_start", start, 1);
    chk("t1_fields", {mode, offA, offW}, {2'd0, 10'h000, 10'h040});
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_pulse", start, 0);
    wait_done(n);
    chk("t1_len", n, 229);
    chk("t1_tag", done_tag, 1);
    chk("t1_err", done_err, 0);
    chk("t1_ntt_rst", ntt_rst, 1);
    chk("t1_w_stable", offW, 10'h040);
    @(negedge clk);
    chk("t1_after", {done, ntt_rst, busy}, 0);

    // ADDSUB subtract followed by MULT
    fin_delay = 5;
    push(2'd3, 1'b1, 10'h100, 10'h120, 10'h140, 2'd2, st);
    push(2'd2, 1'b0, 10'h200, 10'h210, 10'h220, 2'd3, st);
    wait_start(n);
    chk("as_mode", mode, 3);
    chk("as_sub", is_add_or_sub, 1);
    chk("as_offs", {offA, offB, offW}, {10'h100, 10'h120, 10'h140});
    wait_done(n);
    chk("as_tag", done_tag, 2);
    chk("as_mode_hold", mode, 3);
    wait_start(n);
    chk("mu_mode", mode, 2);
    chk("mu_sub", is_add_or_sub, 0);
    chk("mu_offs", {offA, offB, offW}, {10'h200, 10'h210, 10'h220});
    wait_done(n);
    chk("mu_tag", done_tag, 3);
    @(negedge clk);

    // minimum start-to-start gap
    fin_delay = 1;
    sq.delete();
    push(2'd0, 1'b0, 10'h001, 10'h002, 10'h003, 2'd0, st);
    push(2'd1, 1'b0, 10'h004, 10'h005, 10'h006, 2'd1, st);
    k = 0;
    while (sq.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("gap_starts", sq.size(), 2);
    if (sq.size() >= 2) chk("gap", sq[1] - sq[0], 4);
    repeat (10) @(negedge clk);

    // six back-to-back commands through a depth-4 FIFO
    fin_delay = 20;
    dq_tag.delete();
    dq_err.delete();
    peak = 0;
    for (int i = 0; i < 5; i++)
      push(2'd2, 1'b0, 10'(i * 16), 10'(i * 16 + 1), 10'(i * 16 + 2),
           tg[i], st);
    chk("six_ready", cif.cmd_ready, 0);
    chk("six_level", fifo_level, 4);
    push(2'd2, 1'b0, 10'h050, 10'h051, 10'h052, tg[5], st);
    chk("six_stall", st > 0, 1);
    k = 0;
    while (dq_tag.size() < 6 && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("six_count", dq_tag.size(), 6);
    for (int i = 0; i < 6 && i < dq_tag.size(); i++) begin
      chk($sformatf("six_tag%0d", i), dq_tag[i], tg[i]);
      chk($sformatf("six_err%0d", i), dq_err[i], 0);
    end
    chk("six_peak", peak, 4);
    repeat (3) @(negedge clk);

    // watchdog: finish never raised
    fin_delay = 0;
    push(2'd1, 1'b0, 10'h010, 10'h020, 10'h030, 2'd2, st);
    wait_start(n);
    wait_done(n);
    chk("wd_len", n, 301);
    chk("wd_err", done_err, 1);
    chk("wd_ntt_rst", ntt_rst, 1);
    chk("wd_tag", done_tag, 2);
    @(negedge clk);
    fin_delay = 3;
    push(2'd0, 1'b0, 10'h011, 10'h022, 10'h033, 2'd3, st);
    wait_start(n);
    wait_done(n);
    chk("wd_next_len", n, 4);
    chk("wd_next_err", done_err, 0);
    chk("wd_next_tag", done_tag, 3);
    @(negedge clk);

    // finish in the same cycle as the timeout
    fin_delay = 300;
    push(2'd0, 1'b0, 10'h3ff, 10'h3fe, 10'h3fd, 2'd1, st);
    wait_start(n);
    wait_done(n);
    chk("tie_len", n, 301);
    chk("tie_err", done_err, 0);
    @(negedge clk);

    // reset in the middle of BUSY with two queued commands
    fin_delay = 0;
    push(2'd0, 1'b0, 10'h001, 10'h001, 10'h001, 2'd0, st);
    push(2'd1, 1'b0, 10'h002, 10'h002, 10'h002, 2'd1, st);
    push(2'd2, 1'b0, 10'h003, 10'h003, 10'h003, 2'd2, st);
    repeat (50) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_level", fifo_level, 2);
    dq_tag.delete();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pulses", {start, done, done_err, ntt_rst, busy}, 0);
    chk("ar_level", fifo_level, 0);
    chk("ar_ready", cif.cmd_ready, 1);
    chk("ar_offs", {offA, offB, offW}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("ar_no_done", dq_tag.size(), 0);
    chk("ar_idle", busy, 0);
    fin_delay = 2;
    push(2'd3, 1'b0, 10'h003, 10'h004, 10'h005, 2'd1, st);
    chk("ar_pre_start", start, 0);
    @(negedge clk);
    chk("ar_start", start, 1);
    chk("ar_offs2", {offA, offB, offW}, {10'h003, 10'h004, 10'h005});
    wait_done(n);
    chk("ar_tag", done_tag, 1);
    chk("ar_err", done_err, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
